vga_timing_gen: RTL and testbench
=================================

Name: vga_timing_gen

Overview:
- Source end of the pixel-coordinate interface consumed by every sprite/board renderer: generates DrawX, DrawY, blank and the VGA sync strobes from one pixel clock.
- Renderers look up ROM/palette on the coordinates and register colour one cycle later.
- This block delays the sync/blank strobes by PIPE_DELAY cycles so they line up with that registered colour.
- Also provides frame and vblank pulses for game-state update logic.

Parameters:
- H_VISIBLE, 640, active pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync width (pixels)
- H_BP, 48, horizontal back porch (pixels); H_TOTAL = sum of the four horizontal parameters = 800
- V_VISIBLE, 480, active lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync width (lines)
- V_BP, 33, vertical back porch (lines); V_TOTAL = sum of the four vertical parameters = 525
- PIPE_DELAY, 1, register stages applied to hs/vs/blank (legal range 0..4)

Ports:
- vga_clk  input  1  pixel clock; all logic on posedge
- reset  input  1  synchronous, active-high reset
- DrawX  output  10  current horizontal counter (undelayed)
- DrawY  output  10  current vertical counter (undelayed)
- blank  output  1  1 = visible pixel (display enable), delayed by PIPE_DELAY
- hs  output  1  horizontal sync, active low, delayed by PIPE_DELAY
- vs  output  1  vertical sync, active low, delayed by PIPE_DELAY
- frame_start  output  1  one-cycle pulse at counter (0,0), undelayed
- vblank_pulse  output  1  one-cycle pulse at counter (0,V_VISIBLE), undelayed

Behaviour:
- Counters
  - hc counts 0..H_TOTAL-1 and wraps to 0.
  - vc increments only on the hc wrap cycle; vc wraps to 0 when hc and vc wrap together.
  - DrawX = hc, DrawY = vc, both combinational from the counter registers.
  - H_TOTAL and V_TOTAL must each be ≤ 1024; elaboration error otherwise.
- Raw strobes (from counters)
  - blank_raw = (hc < H_VISIBLE) && (vc < V_VISIBLE).
  - hs_raw = 0 iff H_VISIBLE+H_FP ≤ hc < H_VISIBLE+H_FP+H_SYNC (656..751 at defaults).
  - vs_raw = 0 iff V_VISIBLE+V_FP ≤ vc < V_VISIBLE+V_FP+V_SYNC (lines 490..491 at defaults), for the full line duration.
- Delay line
  - hs/vs/blank = raw strobes passed through PIPE_DELAY flops.
  - PIPE_DELAY=0 makes them combinational from the counters.
- Pulses
  - frame_start = (hc==0 && vc==0) && !reset.
  - vblank_pulse = (hc==0 && vc==V_VISIBLE) && !reset.
- Reset (synchronous)
  - While reset=1: hc=vc=0, so DrawX=DrawY=0.
  - Every delay stage is forced to its inactive value (blank=0, hs=1, vs=1).
  - frame_start=0, vblank_pulse=0.
  - With PIPE_DELAY=0, blank/hs/vs are also forced inactive while reset=1.
- Reset release
  - The first cycle with reset=0 has counters at (0,0): frame_start=1, blank_raw=1.
  - Delayed blank goes 1 after PIPE_DELAY further cycles.
- Reset mid-frame
  - The cycle after reset is sampled high, counters are (0,0) and all delayed outputs are inactive, regardless of prior position.
  - No partial sync pulse persists past the reset cycle.
- Period: line = H_TOTAL cycles; frame = H_TOTAL*V_TOTAL cycles (420000 at defaults). No other stall or enable.

Optional Feature:
- VGA_FRAME_CNT_EN
  - Defined: adds output frame_cnt [15:0].
  - frame_cnt is reset to 0 and increments by 1 in the cycle following each frame_start pulse, wrapping 65535→0. Used for animation timing.
  - Not defined: the port and its register are absent; all other behaviour is identical.

Test Plan:
- Release reset (defaults) → first cycle DrawX=0, DrawY=0, frame_start=1, blank=0; blank=1 on the next cycle; hs=vs=1 throughout.
- Run one line → DrawX sequence 0..799 then 0 with DrawY 0→1 on wrap; hs low for exactly 96 cycles, starting 1 cycle after DrawX=656; blank high for 640 cycles per visible line.
- Run a full frame → vs low for exactly 1600 cycles, starting 1 cycle after (DrawX,DrawY)=(0,490); vblank_pulse once at (0,480); blank=0 throughout lines 480..524; next frame_start 420000 cycles after the first.
- Assert reset for 1 cycle at (300,200) → next cycle DrawX=DrawY=0, blank=0, hs=vs=1; frame_start=1 on the first non-reset cycle; timing restarts from (0,0).
- PIPE_DELAY=0 → hs falls in the same cycle DrawX=656; blank falls in the same cycle DrawX=640.
- With VGA_FRAME_CNT_EN → frame_cnt=0 after reset, 1 after the first frame_start, 3 after the third frame_start.

Source files
------------

// File: rtl/vga_timing_gen_if.sv
// vga_timing_gen_if: pixel-coordinate and sync bundle from the timing generator to renderers.
interface vga_timing_gen_if;
  logic [9:0] DrawX;
  logic [9:0] DrawY;
  logic blank;
  logic hs;
  logic vs;
  logic frame_start;
  logic vblank_pulse;
`ifdef VGA_FRAME_CNT_EN
  logic [15:0] frame_cnt;
  modport master(output DrawX, DrawY, blank, hs, vs, frame_start, vblank_pulse, frame_cnt);
  modport slave(input DrawX, DrawY, blank, hs, vs, frame_start, vblank_pulse, frame_cnt);
`else
  modport master(output DrawX, DrawY, blank, hs, vs, frame_start, vblank_pulse);
  modport slave(input DrawX, DrawY, blank, hs, vs, frame_start, vblank_pulse);
`endif
endinterface

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: VGA counters, sync/blank strobes delayed to match registered colour, frame/vblank pulses.
// Optional VGA_FRAME_CNT_EN adds a 16-bit frame counter.
module vga_timing_gen #(
  parameter int H_VISIBLE = 640,
  parameter int H_FP = 16,
  parameter int H_SYNC = 96,
  parameter int H_BP = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FP = 10,
  parameter int V_SYNC = 2,
  parameter int V_BP = 33,
  parameter int PIPE_DELAY = 1
) (
  input logic vga_clk,
  input logic reset,
  vga_timing_gen_if.master vga
);
  localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;
  localparam logic [10:0] HV = 11'(H_VISIBLE);
  localparam logic [10:0] HS0 = 11'(H_VISIBLE + H_FP);
  localparam logic [10:0] HS1 = 11'(H_VISIBLE + H_FP + H_SYNC);
  localparam logic [9:0] HL = 10'(H_TOTAL - 1);
  localparam logic [10:0] VV = 11'(V_VISIBLE);
  localparam logic [10:0] VS0 = 11'(V_VISIBLE + V_FP);
  localparam logic [10:0] VS1 = 11'(V_VISIBLE + V_FP + V_SYNC);
  localparam logic [9:0] VL = 10'(V_TOTAL - 1);
  localparam logic [2:0] IDLE = 3'b011;
  if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_total_chk
    $error("vga_timing_gen: H_TOTAL and V_TOTAL must be <= 1024");
  end
  if (PIPE_DELAY < 0 || PIPE_DELAY > 4) begin : g_pipe_chk
    $error("vga_timing_gen: PIPE_DELAY must be 0..4");
  end
  logic [9:0] hc, vc;
  logic [10:0] hx, vx;
  logic hw, vw;
  logic [2:0] raw, out;
  assign hx = {1'b0, hc};
  assign vx = {1'b0, vc};
  assign hw = hc == HL;
  assign vw = vc == VL;
  always_ff @(posedge vga_clk) begin
    if (reset) begin
      hc <= '0;
      vc <= '0;
    end else begin
      hc <= hw ? '0 : hc + 10'd1;
      if (hw) vc <= vw ? '0 : vc + 10'd1;
    end
  end
  // {blank, hs, vs}; syncs are active low
  assign raw = {(hx < HV) && (vx < VV), !(hx >= HS0 && hx < HS1), !(vx >= VS0 && vx < VS1)};
  if (PIPE_DELAY == 0) begin : g_comb
    assign out = reset ? IDLE : raw;
  end else begin : g_pipe
    logic [2:0] st [PIPE_DELAY];
    always_ff @(posedge vga_clk) begin
      if (reset) begin
        for (int i = 0; i < PIPE_DELAY; i++) st[i] <= IDLE;
      end else begin
        st[0] <= raw;
        for (int i = 1; i < PIPE_DELAY; i++) st[i] <= st[i-1];
      end
    end
    assign out = st[PIPE_DELAY-1];
  end
  assign {vga.blank, vga.hs, vga.vs} = out;
  assign vga.DrawX = hc;
  assign vga.DrawY = vc;
  assign vga.frame_start = hc == '0 && vc == '0 && !reset;
  assign vga.vblank_pulse = hc == '0 && vx == VV && !reset;
`ifdef VGA_FRAME_CNT_EN
  logic [15:0] fcnt;
  always_ff @(posedge vga_clk) begin
    if (reset) fcnt <= '0;
    else if (vga.frame_start) fcnt <= fcnt + 16'd1;
  end
  assign vga.frame_cnt = fcnt;
`endif
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: scoreboard bench; expected (phase, cycle, dut, signal, value) entries checked by a negedge monitor.
module tb_vga_timing_gen;
  localparam int SX = 0, SY = 1, SB = 2, SH = 3, SV = 4, SF = 5, SVB = 6, SC = 7;
  localparam int NH = 8, NV = 9, NB = 10, NF = 11, NVB = 12;
  localparam int M = 0, Z = 1, D = 2;
  typedef struct {int ph; int c; int d; int s; int v;} exp_t;
  string names [13] = '{"DrawX", "DrawY", "blank", "hs", "vs", "frame_start", "vblank_pulse",
                        "frame_cnt", "hs_low_cnt", "vs_low_cnt", "blank_cnt", "fs_cnt", "vb_cnt"};
  logic clk, reset;
  exp_t q[$];
  int v [3][13];
  int errs = 0, checks = 0, ph = 0, mph = -1, c = 0;
  logic prev = 1'b0;
  vga_timing_gen_if vm();
  vga_timing_gen_if vz();
  vga_timing_gen_if vd();
  vga_timing_gen #(.V_VISIBLE(20), .V_FP(3), .V_SYNC(2), .V_BP(5)) u_m (.vga_clk(clk), .reset(reset), .vga(vm));
  vga_timing_gen #(.V_VISIBLE(4), .V_FP(1), .V_SYNC(1), .V_BP(1), .PIPE_DELAY(0)) u_z (.vga_clk(clk), .reset(reset), .vga(vz));
  vga_timing_gen u_d (.vga_clk(clk), .reset(reset), .vga(vd));
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic e(input int cy, input int d, input int s, input int val);
    q.push_back('{ph, cy, d, s, val});
  endtask
  task automatic snap(input int d, input int x, input int y, input int b, input int h, input int vv,
                      input int f, input int vb, input int cn);
    v[d][SX] = x; v[d][SY] = y; v[d][SB] = b; v[d][SH] = h;
    v[d][SV] = vv; v[d][SF] = f; v[d][SVB] = vb; v[d][SC] = cn;
  endtask
  always @(negedge clk) begin
    int cm, cz;
`ifdef VGA_FRAME_CNT_EN
    cm = int'(vm.frame_cnt);
    cz = int'(vz.frame_cnt);
`else
    cm = 0;
    cz = 0;
`endif
    snap(M, int'(vm.DrawX), int'(vm.DrawY), int'(vm.blank), int'(vm.hs), int'(vm.vs), int'(vm.frame_start), int'(vm.vblank_pulse), cm);
    snap(Z, int'(vz.DrawX), int'(vz.DrawY), int'(vz.blank), int'(vz.hs), int'(vz.vs), int'(vz.frame_start), int'(vz.vblank_pulse), cz);
    snap(D, int'(vd.DrawX), int'(vd.DrawY), int'(vd.blank), int'(vd.hs), int'(vd.vs), int'(vd.frame_start), int'(vd.vblank_pulse), 0);
    if (reset) begin
      if (!prev) begin
        mph++;
        for (int d = 0; d < 3; d++) for (int k = NH; k <= NVB; k++) v[d][k] = 0;
      end
      c = -1;
    end else c++;
    for (int i = q.size() - 1; i >= 0; i--) begin
      if (q[i].ph == mph && q[i].c == c) begin
        checks++;
        if (v[q[i].d][q[i].s] != q[i].v) begin
          errs++;
          $display("FAIL ph=%0d c=%0d dut=%0d %s got=%0d exp=%0d", mph, c, q[i].d, names[q[i].s], v[q[i].d][q[i].s], q[i].v);
        end
        q.delete(i);
      end
    end
    if (!reset) begin
      for (int d = 0; d < 3; d++) begin
        v[d][NH] += v[d][SH] == 0 ? 1 : 0;
        v[d][NV] += v[d][SV] == 0 ? 1 : 0;
        v[d][NB] += v[d][SB];
        v[d][NF] += v[d][SF];
        v[d][NVB] += v[d][SVB];
      end
    end
    prev = reset;
  end
  initial begin
    reset = 1'b1;
    ph = 0;
    e(-1, M, SX, 0); e(-1, M, SY, 0); e(-1, M, SB, 0); e(-1, M, SH, 1); e(-1, M, SV, 1);
    e(-1, M, SF, 0); e(-1, M, SVB, 0); e(-1, Z, SB, 0); e(-1, Z, SH, 1); e(-1, Z, SV, 1);
    e(0, M, SX, 0); e(0, M, SY, 0); e(0, M, SF, 1); e(0, M, SB, 0); e(0, M, SH, 1); e(0, M, SV, 1);
    e(0, Z, SB, 1); e(0, Z, SF, 1); e(0, D, SF, 1); e(0, D, SB, 0);
    e(1, M, SX, 1); e(1, M, SB, 1); e(1, M, SF, 0); e(1, D, SB, 1);
    e(640, M, SX, 640); e(640, M, SB, 1); e(640, Z, SX, 640); e(640, Z, SB, 0); e(641, M, SB, 0);
    e(656, M, SX, 656); e(656, M, SH, 1); e(656, Z, SH, 0); e(657, M, SH, 0);
    e(751, Z, SH, 0); e(752, M, SH, 0); e(752, Z, SH, 1); e(753, M, SH, 1);
    e(799, M, SX, 799); e(799, M, SY, 0);
    e(800, M, SX, 0); e(800, M, SY, 1); e(800, M, NH, 96); e(800, M, NB, 640);
    e(800, Z, NH, 96); e(800, D, SX, 0); e(800, D, SY, 1);
    e(3200, Z, SVB, 1); e(3200, Z, SY, 4); e(3999, Z, SV, 1); e(4000, Z, SV, 0);
    e(5600, Z, SF, 1); e(5600, Z, NF, 1); e(5600, Z, NV, 800);
    e(16000, M, SVB, 1); e(16000, M, NB, 12800); e(16001, M, SVB, 0); e(16001, M, SB, 0); e(16001, D, SB, 1);
    e(18400, M, SV, 1); e(18401, M, SV, 0); e(19099, M, SV, 0);
    e(19099, D, SX, 699); e(19099, D, SY, 23); e(19099, D, NV, 0); e(19099, D, NVB, 0);
`ifdef VGA_FRAME_CNT_EN
    e(0, M, SC, 0); e(1, M, SC, 1); e(0, Z, SC, 0); e(1, Z, SC, 1); e(11201, Z, SC, 3);
`endif
    ph = 1;
    e(-1, M, SX, 700); e(-1, M, SY, 23); e(-1, M, SF, 0); e(-1, M, SH, 0); e(-1, M, SV, 0);
    e(0, M, SX, 0); e(0, M, SY, 0); e(0, M, SB, 0); e(0, M, SH, 1); e(0, M, SV, 1); e(0, M, SF, 1);
    e(0, D, SX, 0); e(0, D, SY, 0); e(1, M, SB, 1);
    e(18400, M, SV, 1); e(18401, M, SV, 0); e(20000, M, SV, 0); e(20001, M, SV, 1);
    e(24000, M, SF, 1); e(24000, M, SX, 0); e(24000, M, SY, 0); e(24000, M, NF, 1);
    e(24000, M, NV, 1600); e(24000, M, NVB, 1); e(24000, M, NB, 12800);
`ifdef VGA_FRAME_CNT_EN
    e(0, M, SC, 0); e(1, M, SC, 1); e(24001, M, SC, 2);
`endif
    repeat (3) @(posedge clk);
    #1;
    checks += 4;
    if (vm.DrawX !== 10'd0) begin errs++; $display("FAIL reset DrawX=%0d", vm.DrawX); end
    if (vm.blank !== 1'b0) begin errs++; $display("FAIL reset blank=%b", vm.blank); end
    if (vm.hs !== 1'b1) begin errs++; $display("FAIL reset hs=%b", vm.hs); end
    if (vz.blank !== 1'b0) begin errs++; $display("FAIL reset z blank=%b", vz.blank); end
    reset = 1'b0;
    repeat (19100) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    repeat (24010) @(posedge clk);
    for (int i = 0; i < 50 && q.size() > 0; i++) @(posedge clk);
    foreach (q[i]) begin
      checks++;
      errs++;
      $display("FAIL unchecked ph=%0d c=%0d dut=%0d %s exp=%0d", q[i].ph, q[i].c, q[i].d, names[q[i].s], q[i].v);
    end
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
